// File: rtl/cache_pkg.sv
// cache_pkg: shared geometry and FSM encoding for the direct-mapped data cache.
package cache_pkg;
  localparam int TAG_W = 3;
  localparam int IDX_W = 3;
  localparam int OFF_W = 2;
  localparam int BLOCK_W = 32;
  localparam int NUM_BLOCKS = 1 << IDX_W;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MEM_RD = 2'd1,
    MEM_WB = 2'd2,
    UPDATE = 2'd3
  } state_t;
endpackage

// File: rtl/dcache_line_array.sv
// dcache_line_array: per-line data/tag storage plus valid/dirty bits with a byte write port and a block fill port.
module dcache_line_array
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [IDX_W-1:0]   i_idx,
  input  logic [OFF_W-1:0]   i_off,
  input  logic               i_byte_we,
  input  logic [7:0]         i_byte,
  input  logic               i_fill_we,
  input  logic [TAG_W-1:0]   i_fill_tag,
  input  logic [BLOCK_W-1:0] i_fill_data,
  output logic [BLOCK_W-1:0] o_data,
  output logic [TAG_W-1:0]   o_tag,
  output logic               o_valid,
  output logic               o_dirty
);
  logic [BLOCK_W-1:0]    r_data [NUM_BLOCKS];
  logic [TAG_W-1:0]      r_tag  [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] r_valid;
  logic [NUM_BLOCKS-1:0] r_dirty;
  always_ff @(posedge clk) begin
    if (i_fill_we) begin
      r_data[i_idx] <= i_fill_data;
      r_tag[i_idx]  <= i_fill_tag;
    end else if (i_byte_we) begin
      r_data[i_idx][{i_off, 3'b000} +: 8] <= i_byte;
    end
  end
  // Only the status bits need clearing; stale data/tags are harmless once invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill_we) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= 1'b0;
    end else if (i_byte_we) begin
      r_dirty[i_idx] <= 1'b1;
    end
  end
  assign o_data  = r_data[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped write-back byte cache with block fetch/evict FSM toward data memory.
module dcache_controller
  import cache_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);
  state_t             r_state;
  logic               r_armed;
  logic [7:0]         r_rd_last;
  logic [TAG_W-1:0]   w_tag;
  logic [IDX_W-1:0]   w_idx;
  logic [OFF_W-1:0]   w_off;
  logic [TAG_W-1:0]   w_line_tag;
  logic [BLOCK_W-1:0] w_line_data;
  logic [7:0]         w_byte;
  logic               w_valid, w_dirty, w_hit, w_miss, w_done, w_idle, w_rd_hit, w_wr_hit;

  assign {w_tag, w_idx, w_off} = ADDRESS;
  assign w_idle   = r_state == IDLE;
  assign w_hit    = w_valid && w_line_tag == w_tag;
  assign w_miss   = (READ || WRITE) && !w_hit;
  assign w_rd_hit = w_idle && READ && w_hit;
  assign w_wr_hit = w_idle && WRITE && w_hit;
  assign w_byte   = w_line_data[{w_off, 3'b000} +: 8];
  // r_armed skips the first cycle of a request so a stale MEM_BUSYWAIT low is never taken as done.
  assign w_done   = r_armed && !MEM_BUSYWAIT;
  assign BUSYWAIT = !RESET && (!w_idle || w_miss);
  assign READDATA = w_rd_hit ? w_byte : r_rd_last;

  dcache_line_array u_lines (
    .clk        (CLK),
    .rst        (RESET),
    .i_idx      (w_idx),
    .i_off      (w_off),
    .i_byte_we  (w_wr_hit),
    .i_byte     (WRITEDATA),
    .i_fill_we  (r_state == UPDATE),
    .i_fill_tag (w_tag),
    .i_fill_data(MEM_READDATA),
    .o_data     (w_line_data),
    .o_tag      (w_line_tag),
    .o_valid    (w_valid),
    .o_dirty    (w_dirty)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state       <= IDLE;
      r_armed       <= 1'b0;
      r_rd_last     <= '0;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
    end else begin
      r_armed <= 1'b0;
      if (w_rd_hit) r_rd_last <= w_byte;
      case (r_state)
        IDLE: if (w_miss) begin
          r_state     <= w_dirty ? MEM_WB : MEM_RD;
          MEM_WRITE   <= w_dirty;
          MEM_READ    <= !w_dirty;
          MEM_ADDRESS <= w_dirty ? {w_line_tag, w_idx} : ADDRESS[7:2];
          if (w_dirty) MEM_WRITEDATA <= w_line_data;
        end
        MEM_WB: if (w_done) begin
          r_state     <= MEM_RD;
          MEM_WRITE   <= 1'b0;
          MEM_READ    <= 1'b1;
          MEM_ADDRESS <= ADDRESS[7:2];
        end else r_armed <= 1'b1;
        MEM_RD: if (w_done) begin
          r_state  <= UPDATE;
          MEM_READ <= 1'b0;
        end else r_armed <= 1'b1;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed tests against a line-level cache/memory model with per-cycle output checks.
module tb_dcache_controller;
  logic        CLK = 1'b0;
  logic        RESET, READ, WRITE, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
  logic [7:0]  ADDRESS, WRITEDATA, READDATA;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA, MEM_READDATA;
  int checks = 0, errors = 0;

  always #5 CLK = ~CLK;

  dcache_controller dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
    .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  logic [31:0] mem [64];
  logic [31:0] m_mem [64];
  logic [31:0] m_data [8];
  logic [2:0]  m_tag [8];
  bit          m_valid [8];
  bit          m_dirty [8];
  logic [7:0]  m_last;
  bit          pend, pend_wb;
  int          pend_cycles, miss_rd, miss_wr;
  logic [5:0]  exp_wb_addr;
  logic [31:0] exp_wb_data;
  int          lat = 5;
  bit          lazy = 0;
  int          busy_n, rd_n, wr_n;
  logic [5:0]  seen_rd_addr = '0, seen_wr_addr = '0;
  logic [31:0] seen_wr_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic serve();
    if (MEM_WRITE) mem[MEM_ADDRESS] = MEM_WRITEDATA;
    else MEM_READDATA = mem[MEM_ADDRESS];
  endtask

  // Memory: busy for lat cycles after seeing a request; lazy mode never raises busy at all.
  initial begin
    bit active = 0;
    int cnt = 0;
    MEM_BUSYWAIT = 1'b0;
    MEM_READDATA = '0;
    forever begin
      @(posedge CLK); #1;
      if (RESET) begin
        active = 0;
        MEM_BUSYWAIT = 1'b0;
      end else if (!active && (MEM_READ || MEM_WRITE)) begin
        if (lazy) serve();
        else begin active = 1; cnt = lat; MEM_BUSYWAIT = 1'b1; end
      end else if (active) begin
        if (cnt > 1) cnt--;
        else begin serve(); active = 0; MEM_BUSYWAIT = 1'b0; end
      end
    end
  end

  // Model: a miss is resolved in the model at once (evict then fill); the DUT must stall until it catches up.
  initial begin
    int i, o;
    bit req, hit;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        chk("rst_outputs", 32'({BUSYWAIT, MEM_READ, MEM_WRITE, READDATA, MEM_ADDRESS}), 32'd0);
        chk("rst_wdata", MEM_WRITEDATA, 32'd0);
        for (int k = 0; k < 8; k++) begin m_valid[k] = 0; m_dirty[k] = 0; end
        pend = 0; pend_wb = 0; m_last = '0;
      end else begin
        busy_n += int'(BUSYWAIT); rd_n += int'(MEM_READ); wr_n += int'(MEM_WRITE);
        if (MEM_WRITE) begin seen_wr_addr = MEM_ADDRESS; seen_wr_data = MEM_WRITEDATA; end
        if (MEM_READ) seen_rd_addr = MEM_ADDRESS;
        chk("rd_wr_exclusive", 32'(MEM_READ && MEM_WRITE), 32'd0);
        if (MEM_WRITE) begin
          chk("wb_expected", 32'(pend_wb), 32'd1);
          chk("wb_addr", 32'(MEM_ADDRESS), 32'(exp_wb_addr));
          chk("wb_data", MEM_WRITEDATA, exp_wb_data);
        end
        if (MEM_READ) begin
          chk("fetch_pending", 32'(pend), 32'd1);
          chk("fetch_addr", 32'(MEM_ADDRESS), 32'(ADDRESS[7:2]));
        end
        if (pend) begin
          miss_rd += int'(MEM_READ); miss_wr += int'(MEM_WRITE);
          if (!BUSYWAIT) begin
            chk("wb_occurred", 32'(miss_wr > 0), 32'(pend_wb));
            chk("fetch_occurred", 32'(miss_rd > 0), 32'd1);
            pend = 0; pend_wb = 0;
          end else if (++pend_cycles > 200) begin
            chk("miss_timeout", 32'(pend_cycles), 32'd200);
            pend = 0; pend_wb = 0;
          end
        end
        if (!pend) begin
          i = int'(ADDRESS[4:2]);
          o = int'(ADDRESS[1:0]);
          req = READ || WRITE;
          hit = m_valid[i] && m_tag[i] == ADDRESS[7:5];
          chk("busywait", 32'(BUSYWAIT), 32'(req && !hit));
          if (req && !hit) begin
            pend = 1; pend_cycles = 0; miss_rd = 0; miss_wr = 0;
            pend_wb = m_dirty[i];
            if (pend_wb) begin
              exp_wb_addr = {m_tag[i], ADDRESS[4:2]};
              exp_wb_data = m_data[i];
              m_mem[exp_wb_addr] = m_data[i];
            end
            m_data[i] = m_mem[ADDRESS[7:2]];
            m_tag[i] = ADDRESS[7:5];
            m_valid[i] = 1; m_dirty[i] = 0;
          end else if (READ) m_last = m_data[i][o*8 +: 8];
          else if (WRITE) begin
            m_data[i][o*8 +: 8] = WRITEDATA;
            m_dirty[i] = 1;
          end
        end
        chk("readdata", 32'(READDATA), 32'(m_last));
      end
    end
  end

  task automatic req_op(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d);
    @(posedge CLK); #1;
    READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = d;
    busy_n = 0; rd_n = 0; wr_n = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK);
      if (!BUSYWAIT) break;
    end
    if (BUSYWAIT) chk("req_timeout", 32'(BUSYWAIT), 32'd0);
    @(posedge CLK); #1;
    READ = 0; WRITE = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = 32'h01010101 * k;
    mem[6'h09] = 32'hDDCCBBAA;
    mem[6'h11] = 32'h44332211;
    for (int k = 0; k < 64; k++) m_mem[k] = mem[k];
    RESET = 1; READ = 0; WRITE = 0; ADDRESS = '0; WRITEDATA = '0;
    repeat (3) @(posedge CLK);
    #2 RESET = 0;
    @(negedge CLK);
    chk("idle_busywait", 32'(BUSYWAIT), 32'd0);
    chk("idle_readdata", 32'(READDATA), 32'd0);

    // clean read miss with 5-cycle memory
    req_op(1, 0, 8'h25, 8'h00);
    chk("t1_fetch_addr", 32'(seen_rd_addr), 32'h09);
    chk("t1_stalled", 32'(busy_n > 0), 32'd1);
    chk("t1_readdata", 32'(READDATA), 32'hBB);

    // write hit then read it back
    req_op(0, 1, 8'h25, 8'h7E);
    chk("t2_write_stall", 32'(busy_n), 32'd0);
    req_op(1, 0, 8'h25, 8'h00);
    chk("t2_read_stall", 32'(busy_n), 32'd0);
    chk("t2_readdata", 32'(READDATA), 32'h7E);

    // conflict miss on a dirty line: victim uses stored tag
    req_op(1, 0, 8'h45, 8'h00);
    chk("t3_wb_seen", 32'(wr_n > 0), 32'd1);
    chk("t3_wb_addr", 32'(seen_wr_addr), 32'h09);
    chk("t3_wb_data", seen_wr_data, 32'hDDCC7EAA);
    chk("t3_fetch_addr", 32'(seen_rd_addr), 32'h11);
    chk("t3_readdata", 32'(READDATA), 32'h22);

    // back-to-back read hits across one line
    busy_n = 0; rd_n = 0; wr_n = 0;
    for (int o = 0; o < 4; o++) begin
      @(posedge CLK); #1;
      READ = 1; ADDRESS = 8'(8'h44 + o);
      @(negedge CLK);
      chk("t5_byte", 32'(READDATA), 32'(8'h11 * (o + 1)));
    end
    @(posedge CLK); #1 READ = 0;
    chk("t5_no_stall", 32'(busy_n), 32'd0);
    chk("t5_no_mem", 32'(rd_n + wr_n), 32'd0);

    // memory that never raises busy: first low must be ignored
    lazy = 1;
    req_op(1, 0, 8'hA8, 8'h00);
    chk("t6_rd_cycles", 32'(rd_n >= 2), 32'd1);
    chk("t6_readdata", 32'(READDATA), 32'h2A);
    lazy = 0; lat = 3;

    // async reset in the middle of a fetch
    @(posedge CLK); #1;
    READ = 1; ADDRESS = 8'h6C;
    for (int k = 0; k < 20 && !MEM_READ; k++) @(negedge CLK);
    chk("t4_fetch_started", 32'(MEM_READ), 32'd1);
    @(posedge CLK); #2 RESET = 1;
    #1;
    chk("t4_mem_read_drop", 32'(MEM_READ), 32'd0);
    chk("t4_busy_drop", 32'(BUSYWAIT), 32'd0);
    chk("t4_addr_drop", 32'(MEM_ADDRESS), 32'd0);
    READ = 0;
    @(posedge CLK); #2 RESET = 0;
    req_op(1, 0, 8'h25, 8'h00);
    chk("t4_remiss", 32'(rd_n > 0), 32'd1);
    chk("t4_readdata", 32'(READDATA), 32'h7E);

    // write miss (clean), then write miss evicting that dirty line
    req_op(0, 1, 8'h6D, 8'h5A);
    chk("t7_write_miss_fetch", 32'(seen_rd_addr), 32'h1B);
    req_op(1, 0, 8'h6D, 8'h00);
    chk("t7_readdata", 32'(READDATA), 32'h5A);
    req_op(0, 1, 8'h8D, 8'hC3);
    chk("t7_wb_addr", 32'(seen_wr_addr), 32'h1B);
    chk("t7_wb_data", seen_wr_data, 32'h1B1B5A1B);
    req_op(1, 0, 8'h8D, 8'h00);
    chk("t7_new_byte", 32'(READDATA), 32'hC3);

    repeat (3) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back data cache between the CPU's load/store path and the 32-bit-block data memory.
- The CPU side presents byte reads and writes, holding them while BUSYWAIT is high; the memory side fetches and evicts whole 4-byte blocks.
- It is the store-side partner of the register file: it serves loaded bytes into the register file's write port and accepts store data from the register file's read port.

Parameters:
- NUM_BLOCKS, 8, number of cache lines; index width is log2(NUM_BLOCKS) = 3.
- BLOCK_BYTES, 4, bytes per line; offset width is 2 and the memory data width is 32.
- ADDR_W, 8, CPU byte-address width; tag width is ADDR_W-5 = 3.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- RESET  input  1  asynchronous, active-high reset.
- READ  input  1  CPU load request; held until BUSYWAIT is low.
- WRITE  input  1  CPU store request; held until BUSYWAIT is low. Never asserted together with READ.
- ADDRESS  input  8  CPU byte address: tag[7:5], index[4:2], offset[1:0].
- WRITEDATA  input  8  store byte.
- READDATA  output  8  load byte.
- BUSYWAIT  output  1  CPU stall request.
- MEM_READ  output  1  memory block-read request.
- MEM_WRITE  output  1  memory block-write request.
- MEM_ADDRESS  output  6  memory block address {tag,index}.
- MEM_WRITEDATA  output  32  evicted block; byte0 is in [7:0].
- MEM_READDATA  input  32  fetched block.
- MEM_BUSYWAIT  input  1  high while the memory is servicing a request.

Behaviour:
- Storage per line: data[31:0], tag[2:0], valid, dirty.
- hit = valid[idx] && tag[idx]==ADDRESS[7:5]. It is combinational from the current ADDRESS.

Reset (async, any state):
- All valid and dirty bits cleared; state = IDLE.
- MEM_READ, MEM_WRITE, BUSYWAIT, READDATA, MEM_ADDRESS and MEM_WRITEDATA all go to 0.
- Data and tag arrays need not be cleared.

BUSYWAIT:
- High when (READ|WRITE) && !hit in IDLE, or whenever state != IDLE.
- Otherwise low.
- BUSYWAIT is high whenever RESET is low and there is a pending miss.

Read hit:
- READDATA = byte[offset] of the line, combinational, with zero stall cycles.
- When no read hit is present, READDATA holds its last value.

Write hit:
- At the posedge, byte[offset] <= WRITEDATA and dirty[idx] <= 1.
- Zero stall cycles; BUSYWAIT stays low.

FSM states: IDLE, MEM_RD, MEM_WB, UPDATE.
- IDLE: on a miss with dirty[idx]=0 go to MEM_RD; on a miss with dirty[idx]=1 go to MEM_WB.
- MEM_WB: MEM_WRITE=1, MEM_ADDRESS={stored tag, idx}, MEM_WRITEDATA=line data. When MEM_BUSYWAIT=0 at a posedge after the request was issued, go to MEM_RD.
- MEM_RD: MEM_READ=1, MEM_ADDRESS=ADDRESS[7:2]. When MEM_BUSYWAIT=0 at a posedge after the request was issued, go to UPDATE.
- UPDATE: MEM_READ and MEM_WRITE are 0. At the posedge the line is written with MEM_READDATA, tag <= ADDRESS[7:5], valid <= 1, dirty <= 0, then go to IDLE.
- Back in IDLE the held request now hits: a read completes combinationally, and a write completes at the next posedge (setting dirty).

Request qualification:
- The memory-done condition is sampled only one or more cycles after MEM_READ/MEM_WRITE rose, so a stale MEM_BUSYWAIT=0 is ignored.
- MEM_READ and MEM_WRITE are never both high.

Latency:
- Clean miss: 1 + memory latency + 1 (UPDATE) cycles before the hit cycle.
- Dirty miss: adds a full write-back transaction.

Boundary conditions:
- Changing ADDRESS while BUSYWAIT is high is illegal; the CPU holds the request.
- RESET asserted mid-miss: the FSM aborts immediately and memory requests drop to 0.
- A request with the same index but a different tag evicts. The victim address uses the stored tag, not the request tag.
- READ=WRITE=0 in IDLE: no state change; BUSYWAIT is 0.

Decomposition:
- Shared package (cache_pkg): state encodings (IDLE=2'd0, MEM_RD=2'd1, MEM_WB=2'd2, UPDATE=2'd3), TAG_W=3, IDX_W=3, OFF_W=2, BLOCK_W=32.
- Natural sub-module: dcache_line_array, holding the data/tag/valid/dirty storage with async-clear valid/dirty, a byte write port and a block-fill port.
- The FSM and hit logic stay in dcache_controller.

Test Plan:
1. Reset, then READ ADDRESS=8'h25 -> BUSYWAIT=1; MEM_READ=1, MEM_ADDRESS=6'h09. Memory returns 32'hDDCCBBAA after 5 cycles -> UPDATE, then READDATA=8'hBB with BUSYWAIT=0.
2. After test 1, WRITE 8'h25 with 8'h7E -> no stall; subsequent READ 8'h25 gives 8'h7E and dirty[1]=1.
3. After test 2, READ 8'h45 (same index 1, tag 2) -> MEM_WRITE=1, MEM_ADDRESS=6'h09, MEM_WRITEDATA=32'hDDCC7EAA. Then MEM_READ with MEM_ADDRESS=6'h11, then a hit.
4. RESET pulsed while in MEM_RD (mid-wait) -> MEM_READ=0, BUSYWAIT=0 and state IDLE immediately (async); the earlier READ 8'h25 misses again.
5. Back-to-back read hits to offsets 0..3 of one line -> READDATA tracks each byte with zero BUSYWAIT cycles; MEM_READ and MEM_WRITE are never asserted.
6. Stale MEM_BUSYWAIT=0 held low at miss onset -> the controller stays in MEM_RD for at least one cycle and completes only on a post-request low.
